// File: rtl/usd_cmd_arbiter.sv
// Round-robin arbiter that lets two requesters share one sdEngine command port.
// Only one command is in flight at a time, and a timeout covers an engine that never answers.
module usd_cmd_arbiter #(
    parameter logic [15:0] TIMEOUT = 16'd50000
) (
    input  logic        sdClk,
    input  logic        sysRst,
    input  logic        req0Valid,
    input  logic        req1Valid,
    input  logic [71:0] req0Cmd,
    input  logic [71:0] req1Cmd,
    output logic        req0Ready,
    output logic        req1Ready,
    output logic        rsp0Valid,
    output logic        rsp1Valid,
    input  logic        rsp0Ready,
    input  logic        rsp1Ready,
    output logic [35:0] rspData,
    output logic        rspTimeout,
    output logic        engCmdValid,
    output logic [71:0] engCmd,
    input  logic        engCmdReady,
    input  logic        engRspValid,
    input  logic [35:0] engRspData,
    output logic        grantOwner,
    output logic        busy,
    output logic [7:0]  strayCnt
);
    localparam logic [35:0] TIMEOUT_WORD = 36'h8_0000_0000;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, RETURN} arbStateT;

    arbStateT    state;
    logic        lastGrant;
    logic [15:0] waitCnt;
    logic        grantHit;
    logic        grantIdx;
    logic        ownerTaking;

    // The grant is decoded combinationally so that reqNReady answers the valid seen in the same cycle.
    always_comb begin
        grantHit = 1'b0;
        grantIdx = 1'b0;
        if (!sysRst && state == IDLE) begin
            if (req0Valid && req1Valid) begin
                grantHit = 1'b1;
                grantIdx = ~lastGrant;
            end else if (req0Valid) begin
                grantHit = 1'b1;
            end else if (req1Valid) begin
                grantHit = 1'b1;
                grantIdx = 1'b1;
            end
        end
    end

    assign req0Ready   = grantHit && !grantIdx;
    assign req1Ready   = grantHit && grantIdx;
    assign ownerTaking = grantOwner ? rsp1Ready : rsp0Ready;

    always_ff @(posedge sdClk or posedge sysRst) begin
        if (sysRst) begin
            state       <= IDLE;
            lastGrant   <= 1'b1;
            waitCnt     <= 16'd0;
            rsp0Valid   <= 1'b0;
            rsp1Valid   <= 1'b0;
            rspData     <= 36'd0;
            rspTimeout  <= 1'b0;
            engCmdValid <= 1'b0;
            engCmd      <= 72'd0;
            grantOwner  <= 1'b0;
            busy        <= 1'b0;
            strayCnt    <= 8'd0;
        end else begin
            // An engine strobe outside WAIT_RSP has no command to answer, so it is only counted.
            if (engRspValid && state != WAIT_RSP && strayCnt != 8'hFF) begin
                strayCnt <= strayCnt + 8'd1;
            end

            case (state)
                IDLE: begin
                    if (grantHit) begin
                        engCmd      <= grantIdx ? req1Cmd : req0Cmd;
                        engCmdValid <= 1'b1;
                        grantOwner  <= grantIdx;
                        busy        <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (engCmdReady) begin
                        engCmdValid <= 1'b0;
                        waitCnt     <= 16'd0;
                        state       <= WAIT_RSP;
                    end
                end
                WAIT_RSP: begin
                    waitCnt <= waitCnt + 16'd1;
                    // If the engine answers on the last timeout cycle, its answer beats the timeout.
                    if (engRspValid) begin
                        rspData    <= engRspData;
                        rspTimeout <= 1'b0;
                        rsp0Valid  <= !grantOwner;
                        rsp1Valid  <= grantOwner;
                        state      <= RETURN;
                    end else if (waitCnt == TIMEOUT - 16'd1) begin
                        rspData    <= TIMEOUT_WORD;
                        rspTimeout <= 1'b1;
                        rsp0Valid  <= !grantOwner;
                        rsp1Valid  <= grantOwner;
                        state      <= RETURN;
                    end
                end
                RETURN: begin
                    if (ownerTaking) begin
                        rsp0Valid <= 1'b0;
                        rsp1Valid <= 1'b0;
                        lastGrant <= grantOwner;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_usd_cmd_arbiter.sv
// Bench for usd_cmd_arbiter: a table of transactions checked against command and response queues,
// followed by hand-written sequences for stray strobes, the RETURN exit cycle and a mid-flight reset.
module tb_usd_cmd_arbiter;
    localparam logic [15:0] TMO = 16'd16;
    localparam int NVEC = 7;

    logic        sdClk = 1'b0;
    logic        sysRst;
    logic        req0Valid, req1Valid;
    logic [71:0] req0Cmd, req1Cmd;
    logic        req0Ready, req1Ready;
    logic        rsp0Valid, rsp1Valid;
    logic        rsp0Ready, rsp1Ready;
    logic [35:0] rspData;
    logic        rspTimeout;
    logic        engCmdValid;
    logic [71:0] engCmd;
    logic        engCmdReady;
    logic        engRspValid;
    logic [35:0] engRspData;
    logic        grantOwner;
    logic        busy;
    logic [7:0]  strayCnt;

    usd_cmd_arbiter #(.TIMEOUT(TMO)) dut (
        .sdClk(sdClk), .sysRst(sysRst),
        .req0Valid(req0Valid), .req1Valid(req1Valid),
        .req0Cmd(req0Cmd), .req1Cmd(req1Cmd),
        .req0Ready(req0Ready), .req1Ready(req1Ready),
        .rsp0Valid(rsp0Valid), .rsp1Valid(rsp1Valid),
        .rsp0Ready(rsp0Ready), .rsp1Ready(rsp1Ready),
        .rspData(rspData), .rspTimeout(rspTimeout),
        .engCmdValid(engCmdValid), .engCmd(engCmd), .engCmdReady(engCmdReady),
        .engRspValid(engRspValid), .engRspData(engRspData),
        .grantOwner(grantOwner), .busy(busy), .strayCnt(strayCnt)
    );

    always #5 sdClk = ~sdClk;

    typedef struct {
        logic        v0;
        logic        v1;
        logic [71:0] c0;
        logic [71:0] c1;
        int          readyDelay;
        int          rspDelay;
        logic [35:0] engData;
        int          rspReadyDelay;
        logic        expOwner;
        logic [71:0] expCmd;
        logic [35:0] expData;
        logic        expTimeout;
    } vecT;

    typedef struct {
        logic        owner;
        logic [35:0] data;
        logic        tmo;
    } rspExpT;

    vecT         vecs [NVEC];
    vecT         v;
    rspExpT      e;
    logic [71:0] cmdQ [$];
    rspExpT      rspQ [$];
    logic [71:0] expCmdWord;
    int          checks = 0;
    int          failures = 0;
    int          lat;
    int          expLat;
    logic        got;
    logic        sawRsp;
    logic        ownerReady;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge sdClk);
        #1;
    endtask

    task automatic checkResetOutputs(input string tag);
        chk({tag, ".readys"}, 72'({req1Ready, req0Ready}), 72'(0));
        chk({tag, ".rspValids"}, 72'({rsp1Valid, rsp0Valid}), 72'(0));
        chk({tag, ".rspData"}, 72'(rspData), 72'(0));
        chk({tag, ".rspTimeout"}, 72'(rspTimeout), 72'(0));
        chk({tag, ".engCmdValid"}, 72'(engCmdValid), 72'(0));
        chk({tag, ".engCmd"}, engCmd, 72'(0));
        chk({tag, ".grantOwner"}, 72'(grantOwner), 72'(0));
        chk({tag, ".busy"}, 72'(busy), 72'(0));
        chk({tag, ".strayCnt"}, 72'(strayCnt), 72'(0));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{v0:1, v1:1, c0:72'h1, c1:72'h2, readyDelay:0, rspDelay:2, engData:36'h0_0000_0900,
                    rspReadyDelay:0, expOwner:0, expCmd:72'h1, expData:36'h0_0000_0900, expTimeout:0};
        vecs[1] = '{v0:1, v1:1, c0:72'h1, c1:72'h2, readyDelay:0, rspDelay:0, engData:36'h0_0000_0A01,
                    rspReadyDelay:1, expOwner:1, expCmd:72'h2, expData:36'h0_0000_0A01, expTimeout:0};
        vecs[2] = '{v0:0, v1:1, c0:72'h9, c1:72'hAB_CDEF_0123_4567_89AB, readyDelay:10, rspDelay:5,
                    engData:36'hF_0000_0001, rspReadyDelay:0, expOwner:1, expCmd:72'hAB_CDEF_0123_4567_89AB,
                    expData:36'hF_0000_0001, expTimeout:0};
        vecs[3] = '{v0:1, v1:0, c0:72'h33, c1:72'h44, readyDelay:0, rspDelay:-1, engData:36'h0,
                    rspReadyDelay:3, expOwner:0, expCmd:72'h33, expData:36'h8_0000_0000, expTimeout:1};
        vecs[4] = '{v0:1, v1:0, c0:72'h5A, c1:72'h0, readyDelay:2, rspDelay:15, engData:36'h1_2345_6789,
                    rspReadyDelay:0, expOwner:0, expCmd:72'h5A, expData:36'h1_2345_6789, expTimeout:0};
        vecs[5] = '{v0:1, v1:1, c0:72'h10, c1:72'hFF_FFFF_FFFF_FFFF_FFFF, readyDelay:1, rspDelay:14,
                    engData:36'hF_FFFF_FFFF, rspReadyDelay:2, expOwner:1, expCmd:72'hFF_FFFF_FFFF_FFFF_FFFF,
                    expData:36'hF_FFFF_FFFF, expTimeout:0};
        vecs[6] = '{v0:1, v1:1, c0:72'h10, c1:72'h20, readyDelay:0, rspDelay:-1, engData:36'h0,
                    rspReadyDelay:0, expOwner:0, expCmd:72'h10, expData:36'h8_0000_0000, expTimeout:1};

        sysRst = 1'b1;
        req0Valid = 1'b1; req1Valid = 1'b1;
        req0Cmd = 72'h0; req1Cmd = 72'h0;
        rsp0Ready = 1'b0; rsp1Ready = 1'b0;
        engCmdReady = 1'b0; engRspValid = 1'b0; engRspData = 36'h0;
        repeat (3) @(negedge sdClk);
        checkResetOutputs("reset");
        nextCycle();
        sysRst = 1'b0; req0Valid = 1'b0; req1Valid = 1'b0;
        @(negedge sdClk);

        for (int i = 0; i < NVEC; i++) begin
            v = vecs[i];
            // Grant cycle: the response and command expectations enter the scoreboard here.
            nextCycle();
            req0Valid = v.v0; req1Valid = v.v1; req0Cmd = v.c0; req1Cmd = v.c1;
            cmdQ.push_back(v.expCmd);
            rspQ.push_back('{owner:v.expOwner, data:v.expData, tmo:v.expTimeout});
            @(negedge sdClk);
            chk($sformatf("v%0d.reqReady", i), 72'({req1Ready, req0Ready}), 72'(v.expOwner ? 2'b10 : 2'b01));
            chk($sformatf("v%0d.idleBusy", i), 72'(busy), 72'(0));

            for (int k = 0; k <= v.readyDelay; k++) begin
                nextCycle();
                req0Valid = 1'b0; req1Valid = 1'b0;
                engCmdReady = (k == v.readyDelay);
                @(negedge sdClk);
                if (k == 0) chk($sformatf("v%0d.grantOwner", i), 72'(grantOwner), 72'(v.expOwner));
                chk($sformatf("v%0d.engCmdValid", i), 72'(engCmdValid), 72'(1));
                chk($sformatf("v%0d.issueBusy", i), 72'(busy), 72'(1));
                if (engCmdValid && engCmdReady) begin
                    expCmdWord = cmdQ.pop_front();
                    chk($sformatf("v%0d.engCmdAccepted", i), engCmd, expCmdWord);
                end else begin
                    chk($sformatf("v%0d.engCmdHeld", i), engCmd, cmdQ[0]);
                end
            end

            lat = 0;
            got = 1'b0;
            while (!got && lat < 40) begin
                nextCycle();
                lat++;
                engCmdReady = 1'b0;
                engRspValid = (v.rspDelay >= 0) && (lat - 1 == v.rspDelay);
                engRspData = engRspValid ? v.engData : {4'($urandom), $urandom};
                @(negedge sdClk);
                got = rsp0Valid || rsp1Valid;
            end
            expLat = (v.rspDelay < 0) ? int'(TMO) + 1 : v.rspDelay + 2;
            chk($sformatf("v%0d.rspLatency", i), 72'(lat), 72'(expLat));

            e = rspQ.pop_front();
            for (int k = 0; k <= v.rspReadyDelay; k++) begin
                if (k > 0 || got) begin
                    chk($sformatf("v%0d.rspValids", i), 72'({rsp1Valid, rsp0Valid}), 72'(e.owner ? 2'b10 : 2'b01));
                    chk($sformatf("v%0d.rspData", i), 72'(rspData), 72'(e.data));
                    chk($sformatf("v%0d.rspTimeout", i), 72'(rspTimeout), 72'(e.tmo));
                    chk($sformatf("v%0d.returnReadys", i), 72'({req1Ready, req0Ready}), 72'(0));
                end
                nextCycle();
                engRspValid = 1'b0;
                ownerReady = (k == v.rspReadyDelay);
                rsp0Ready = e.owner ? 1'b1 : ownerReady;
                rsp1Ready = e.owner ? ownerReady : 1'b1;
                req0Valid = (k < v.rspReadyDelay);
                req1Valid = (k < v.rspReadyDelay);
                @(negedge sdClk);
            end
            chk($sformatf("v%0d.exitReadys", i), 72'({req1Ready, req0Ready}), 72'(0));
            nextCycle();
            rsp0Ready = 1'b0; rsp1Ready = 1'b0; req0Valid = 1'b0; req1Valid = 1'b0;
            @(negedge sdClk);
            chk($sformatf("v%0d.rspDone", i), 72'({rsp1Valid, rsp0Valid}), 72'(0));
            chk($sformatf("v%0d.idleAgain", i), 72'(busy), 72'(0));
        end
        chk("flow.strayCnt", 72'(strayCnt), 72'(0));

        // Engine strobes in IDLE only count, and the count saturates.
        sawRsp = 1'b0;
        for (int i = 0; i < 300; i++) begin
            nextCycle();
            engRspValid = 1'b1;
            engRspData = {4'($urandom), $urandom};
            @(negedge sdClk);
            if (rsp0Valid || rsp1Valid || busy) sawRsp = 1'b1;
            if (i == 5) chk("stray.count5", 72'(strayCnt), 72'(5));
        end
        nextCycle();
        engRspValid = 1'b0;
        @(negedge sdClk);
        chk("stray.saturated", 72'(strayCnt), 72'(8'hFF));
        chk("stray.noResponse", 72'(sawRsp), 72'(0));

        // A requester still waiting must not be granted in the cycle RETURN exits.
        nextCycle();
        req0Valid = 1'b1; req0Cmd = 72'h55;
        @(negedge sdClk);
        chk("seq.grant0", 72'({req1Ready, req0Ready}), 72'(2'b01));
        nextCycle();
        req0Valid = 1'b0; req1Valid = 1'b1; req1Cmd = 72'h77; engCmdReady = 1'b1;
        @(negedge sdClk);
        chk("seq.issueNoGrant", 72'(req1Ready), 72'(0));
        nextCycle();
        engCmdReady = 1'b0; engRspValid = 1'b1; engRspData = 36'h3;
        @(negedge sdClk);
        nextCycle();
        engRspValid = 1'b0;
        @(negedge sdClk);
        chk("seq.rspData", 72'(rspData), 72'(36'h3));
        chk("seq.rsp0Valid", 72'({rsp1Valid, rsp0Valid}), 72'(2'b01));
        nextCycle();
        rsp0Ready = 1'b1;
        @(negedge sdClk);
        chk("seq.noGrantOnExit", 72'(req1Ready), 72'(0));
        nextCycle();
        rsp0Ready = 1'b0;
        @(negedge sdClk);
        chk("seq.grantAfterExit", 72'({req1Ready, req0Ready}), 72'(2'b10));
        chk("seq.rspCleared", 72'({rsp1Valid, rsp0Valid}), 72'(0));
        nextCycle();
        req1Valid = 1'b0; engCmdReady = 1'b1;
        @(negedge sdClk);
        chk("seq.engCmd1", engCmd, 72'h77);
        chk("seq.owner1", 72'(grantOwner), 72'(1));
        nextCycle();
        engCmdReady = 1'b0;
        @(negedge sdClk);
        chk("seq.waitBusy", 72'(busy), 72'(1));

        // A reset while waiting abandons the command, and the first tie afterwards goes to requester 0.
        nextCycle();
        sysRst = 1'b1; req0Valid = 1'b1; req1Valid = 1'b1;
        @(negedge sdClk);
        checkResetOutputs("midReset");
        nextCycle();
        sysRst = 1'b0;
        @(negedge sdClk);
        chk("postReset.tie", 72'({req1Ready, req0Ready}), 72'(2'b01));
        nextCycle();
        req0Valid = 1'b0; req1Valid = 1'b0;
        @(negedge sdClk);
        chk("postReset.engCmd", engCmd, 72'h55);
        chk("postReset.owner", 72'(grantOwner), 72'(0));
        sawRsp = 1'b0;
        repeat (5) begin
            nextCycle();
            @(negedge sdClk);
            if (rsp0Valid || rsp1Valid) sawRsp = 1'b1;
        end
        chk("postReset.noAbortedRsp", 72'(sawRsp), 72'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/usd_cmd_arbiter.md
USD_CMD_ARBITER -- requirements
Module: usd_cmd_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16'd50000: sdClk cycles allowed in WAIT_RSP before a timeout response is forced.
REQ-002 SHALL have ports:
  sdClk  in  1  sole clock, rising edge.
  sysRst  in  1  asynchronous, active-high reset.
  req0Valid, req1Valid  in  1 each  requester command valid.
  req0Cmd, req1Cmd  in  72 each  requester command word (cmdFifo format).
  req0Ready, req1Ready  out  1 each  one-cycle accept pulse.
  rsp0Valid, rsp1Valid  out  1 each  response valid to requester.
  rsp0Ready, rsp1Ready  in  1 each  requester takes response.
  rspData  out  36  response word, shared by both requesters.
  rspTimeout  out  1  current response is a timeout.
  engCmdValid  out  1  command valid to sdEngine.
  engCmd  out  72  command word to sdEngine.
  engCmdReady  in  1  sdEngine accepts command.
  engRspValid  in  1  one-cycle sdEngine result strobe.
  engRspData  in  36  sdEngine result word.
  grantOwner  out  1  index of current/last grant.
  busy  out  1  high in any state other than IDLE.
  strayCnt  out  8  saturating count of unexpected engRspValid.
REQ-003 SHALL operate with one clock; reset is asynchronous and active-high.

Function
REQ-004 SHALL implement states IDLE, ISSUE, WAIT_RSP, RETURN; one command outstanding at a time.
REQ-005 IDLE: if only reqNValid high, grant N; if both high, grant the requester not equal to lastGrant (round-robin); if neither, stay in IDLE.
REQ-006 On grant, reqNReady SHALL be high for exactly that IDLE cycle; reqNCmd is latched; grantOwner=N; next state ISSUE.
REQ-007 ISSUE: engCmdValid=1 and engCmd=latched word, held stable until engCmdReady sampled high; then WAIT_RSP with timeout counter cleared to 0.
REQ-008 engCmdValid SHALL be 0 in every state except ISSUE; engCmd holds its last value otherwise.
REQ-009 WAIT_RSP: counter increments each cycle; engRspValid high -> latch engRspData into rspData, rspTimeout=0, go to RETURN.
REQ-010 WAIT_RSP: counter == TIMEOUT-1 with engRspValid low -> rspData=36'h8_0000_0000, rspTimeout=1, go to RETURN.
REQ-011 engRspValid and counter==TIMEOUT-1 in the same cycle -> the engine response wins (rspTimeout=0).
REQ-012 RETURN: rspNValid=1 for owner N only, rspData/rspTimeout stable until rspNReady high; on that cycle lastGrant=N, go to IDLE.
REQ-013 A new grant SHALL NOT occur in the cycle RETURN exits; earliest next reqReady is the following cycle.
REQ-014 engRspValid in IDLE, ISSUE or RETURN SHALL be ignored for data and SHALL increment strayCnt, saturating at 8'hFF.
REQ-015 rspReady of the non-owner and reqValid during non-IDLE states SHALL have no effect.
REQ-016 A requester SHALL be permitted to drop reqNValid before grant; no grant is made if it is low in the grant cycle.
REQ-017 Latency: grant to engCmdValid = 1 cycle; engRspValid to rspNValid = 1 cycle.

Reset
REQ-018 While sysRst high: state=IDLE, all ready/valid outputs 0, rspData=0, rspTimeout=0, engCmd=0, grantOwner=0, busy=0, strayCnt=0, counter=0, lastGrant=1 (requester 0 wins the first tie).
REQ-019 sysRst asserted mid-operation SHALL abort immediately to reset values; no response is delivered for the aborted command.

Verification
REQ-020 Both reqValid high after reset, cmds 72'h1 and 72'h2, engCmdReady=1, engRspData=36'h0_0000_0900 -> req0 granted first, engCmd=72'h1, rsp0Valid with 36'h0_0000_0900; then req1 granted, engCmd=72'h2.
REQ-021 Only req1Valid, engCmdReady held low for 10 cycles -> engCmdValid high and engCmd stable for all 10 cycles, busy=1, no counter advance.
REQ-022 TIMEOUT=16, engine silent -> rsp0Valid exactly 17 cycles after engCmdReady accepted, rspData=36'h8_0000_0000, rspTimeout=1.
REQ-023 engRspValid on the final timeout cycle with data 36'h1_2345_6789 -> rspData=36'h1_2345_6789, rspTimeout=0.
REQ-024 300 engRspValid pulses in IDLE -> strayCnt=8'hFF, no rspValid asserted.
REQ-025 sysRst pulsed during WAIT_RSP -> all outputs at reset values next cycle, later req0/req1 tie grants req0.
